mem_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one native valid/ready memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) between NUM_REQ masters, such as the APB bridge, a DMA engine and a debug port. It sits between the masters and the downstream peripheral/memory slave. It serialises transactions, holds the granted request stable until the slave completes it, and terminates hung transactions with an error response after a programmable timeout.

---
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that lets NUM_REQ masters share one
// valid/ready memory bus. A winner is picked only in IDLE. Its payload is
// registered onto the mem_* outputs and held until the slave answers or the
// timeout fires.
//
// Handshake: mem_valid stays high with a constant payload from the grant edge
// until the first cycle that either sees mem_ready=1 or hits the timeout.
// That cycle is the completion cycle. The granted requester sees a one-cycle
// req_ready pulse in it, combinationally, with req_rdata/req_err qualified by
// that pulse. A requester keeps req_valid and its payload stable until it
// sees req_ready, or it drops req_valid before the grant edge to withdraw.
module mem_bus_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_addr,
   input  logic [32*NUM_REQ-1:0]  req_wdata,
   input  logic [4*NUM_REQ-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [31:0]            req_rdata,
   output logic                   req_err,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_wstrb,
   input  logic [31:0]            mem_rdata,
   output logic                   busy,
   output logic [2:0]             grant_id
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // A zero TIMEOUT turns the timer compare off entirely.
   localparam logic        TIMEOUT_EN   = (TIMEOUT != 0);
   localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT != 0) ? 16'(TIMEOUT - 1) : 16'd0;

   state_t      state;
   state_t      state_next;
   logic [2:0]  last_grant;
   logic [15:0] timer;

   logic [2:0]  winner;
   logic [2:0]  winner_lo;
   logic [2:0]  winner_hi;
   logic        any_req;
   logic        hi_found;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;

   logic        grant;
   logic        done_ok;
   logic        done_to;
   logic        done;

   // Round-robin pick: the lowest valid index above last_grant wins.
   // Otherwise the search wraps and the lowest valid index overall wins.
   always_comb begin
      winner_lo = '0;
      winner_hi = '0;
      any_req   = 1'b0;
      hi_found  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            winner_lo = 3'(i);
            any_req   = 1'b1;
         end
         if (req_valid[i] && (3'(i) > last_grant)) begin
            winner_hi = 3'(i);
            hi_found  = 1'b1;
         end
      end
      winner = hi_found ? winner_hi : winner_lo;
   end

   // Mux the winner's payload so it can be registered at the grant edge.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == 3'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_wstrb = req_wstrb[4*i +: 4];
         end
      end
   end

   // FSM state register. Reset drops straight to IDLE, aborting any transfer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and completion outputs. A real mem_ready takes
   // precedence over a timeout that lands in the same cycle.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      done_ok    = 1'b0;
      done_to    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               done_ok    = 1'b1;
               state_next = IDLE;
            end else if (TIMEOUT_EN && (timer == TIMEOUT_LAST)) begin
               done_to    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      done      = done_ok | done_to;
      req_err   = done_to;
      req_rdata = done_to ? 32'h0 : mem_rdata;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = done && (grant_id == 3'(i));
      end
   end

   assign busy = (state == BUSY);

   // Bus payload, grant bookkeeping and the saturating stall timer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         last_grant <= 3'(NUM_REQ - 1);
         grant_id   <= '0;
         timer      <= '0;
      end else if (grant) begin
         mem_valid  <= 1'b1;
         mem_addr   <= sel_addr;
         mem_wdata  <= sel_wdata;
         mem_wstrb  <= sel_wstrb;
         last_grant <= winner;
         grant_id   <= winner;
         timer      <= '0;
      end else if (state == BUSY) begin
         if (done) begin
            mem_valid <= 1'b0;
         end
         if (!mem_ready && (timer != 16'hFFFF)) begin
            timer <= timer + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: drives two arbiter instances. The main instance uses the
// default timeout. The second instance uses TIMEOUT=4 for the timeout
// scenarios. Both share payload and mem_rdata. Expected completions are
// queued when a request is issued and popped when req_ready is seen.
module tb_mem_bus_arbiter;

   localparam int N = 3;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_valid_t;
   logic [32*N-1:0] req_addr;
   logic [32*N-1:0] req_wdata;
   logic [4*N-1:0]  req_wstrb;
   logic            mem_ready;
   logic            mem_ready_t;
   logic [31:0]     mem_rdata;

   logic [N-1:0]    req_ready,   req_ready_t;
   logic [31:0]     req_rdata,   req_rdata_t;
   logic            req_err,     req_err_t;
   logic            mem_valid,   mem_valid_t;
   logic [31:0]     mem_addr,    mem_addr_t;
   logic [31:0]     mem_wdata,   mem_wdata_t;
   logic [3:0]      mem_wstrb,   mem_wstrb_t;
   logic            busy,        busy_t;
   logic [2:0]      grant_id,    grant_id_t;

   int total = 0;
   int bad   = 0;

   // Entry layout: {err, id[2:0], rdata[31:0]}
   logic [35:0] exp_q[$];
   logic [35:0] exp_t_q[$];

   mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(255)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut_to (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid_t), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_ready(req_ready_t), .req_rdata(req_rdata_t), .req_err(req_err_t),
      .mem_valid(mem_valid_t), .mem_ready(mem_ready_t), .mem_addr(mem_addr_t),
      .mem_wdata(mem_wdata_t), .mem_wstrb(mem_wstrb_t), .mem_rdata(mem_rdata),
      .busy(busy_t), .grant_id(grant_id_t)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard for the main instance: every req_ready pulse must match the queue head.
   always @(negedge clk) begin
      logic [35:0]  e;
      logic [N-1:0] w;
      if (resetn === 1'b1 && req_ready !== '0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL main_unexpected_ready got=%b want=none", req_ready);
         end else begin
            e = exp_q.pop_front();
            w = N'(1) << e[34:32];
            if (req_ready !== w || req_err !== e[35] || req_rdata !== e[31:0]) begin
               bad++;
               $display("FAIL main_completion got ready=%b err=%b rdata=%h want ready=%b err=%b rdata=%h",
                        req_ready, req_err, req_rdata, w, e[35], e[31:0]);
            end
         end
      end
   end

   // Scoreboard for the timeout instance.
   always @(negedge clk) begin
      logic [35:0]  e;
      logic [N-1:0] w;
      if (resetn === 1'b1 && req_ready_t !== '0) begin
         total++;
         if (exp_t_q.size() == 0) begin
            bad++;
            $display("FAIL to_unexpected_ready got=%b want=none", req_ready_t);
         end else begin
            e = exp_t_q.pop_front();
            w = N'(1) << e[34:32];
            if (req_ready_t !== w || req_err_t !== e[35] || req_rdata_t !== e[31:0]) begin
               bad++;
               $display("FAIL to_completion got ready=%b err=%b rdata=%h want ready=%b err=%b rdata=%h",
                        req_ready_t, req_err_t, req_rdata_t, w, e[35], e[31:0]);
            end
         end
      end
   end

   // Driver helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_payload(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb);
      req_addr[32*id +: 32]  = addr;
      req_wdata[32*id +: 32] = wdata;
      req_wstrb[4*id +: 4]   = wstrb;
   endtask

   // One transaction on the main instance with `stall` wait cycles before mem_ready.
   task automatic run_txn(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int stall, input logic [31:0] rdata);
      set_payload(id, addr, wdata, wstrb);
      req_valid[id] = 1'b1;
      mem_ready     = 1'b0;
      exp_q.push_back({1'b0, 3'(id), rdata});
      step();
      total++;
      if (mem_valid !== 1'b1 || busy !== 1'b1 || grant_id !== 3'(id)) begin
         bad++;
         $display("FAIL txn_grant got valid=%b busy=%b id=%0d want valid=1 busy=1 id=%0d",
                  mem_valid, busy, grant_id, id);
      end
      for (int c = 0; c < stall; c++) begin
         total++;
         if (mem_valid !== 1'b1 || mem_addr !== addr || mem_wdata !== wdata ||
             mem_wstrb !== wstrb || req_ready !== '0) begin
            bad++;
            $display("FAIL txn_hold cyc=%0d got valid=%b addr=%h wdata=%h wstrb=%b ready=%b want 1 %h %h %b 000",
                     c, mem_valid, mem_addr, mem_wdata, mem_wstrb, req_ready, addr, wdata, wstrb);
         end
         step();
      end
      total++;
      if (mem_addr !== addr || mem_wdata !== wdata || mem_wstrb !== wstrb) begin
         bad++;
         $display("FAIL txn_payload got addr=%h wdata=%h wstrb=%b want %h %h %b",
                  mem_addr, mem_wdata, mem_wstrb, addr, wdata, wstrb);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      step();
      total++;
      if (mem_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL txn_release got valid=%b busy=%b want 0 0", mem_valid, busy);
      end
      mem_ready     = 1'b0;
      req_valid[id] = 1'b0;
   endtask

   // Tests
   task automatic test_reset();
      resetn      = 1'b0;
      req_valid   = '0;
      req_valid_t = '0;
      req_addr    = '0;
      req_wdata   = '0;
      req_wstrb   = '0;
      mem_ready   = 1'b0;
      mem_ready_t = 1'b0;
      mem_rdata   = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (mem_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 3'd0) begin
         bad++;
         $display("FAIL reset_ctrl got valid=%b busy=%b id=%0d want 0 0 0", mem_valid, busy, grant_id);
      end
      total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         bad++;
         $display("FAIL reset_payload got addr=%h wdata=%h wstrb=%b want 0 0 0", mem_addr, mem_wdata, mem_wstrb);
      end
      total++;
      if (req_ready !== '0 || req_err !== 1'b0 || req_ready_t !== '0 || req_err_t !== 1'b0) begin
         bad++;
         $display("FAIL reset_resp got ready=%b err=%b ready_t=%b err_t=%b want 0", req_ready, req_err,
                  req_ready_t, req_err_t);
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      run_txn(0, 32'h0400_0000, 32'h0, 4'b0000, 1, 32'h1234_5678);
   endtask

   task automatic test_write_hold();
      run_txn(2, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 5, 32'h0BAD_0002);
   endtask

   task automatic test_round_robin();
      logic [2:0] order [6];
      order = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
      for (int i = 0; i < N; i++) begin
         set_payload(i, 32'h1000_0000 * (i + 1), 32'h0, 4'b0000);
      end
      mem_rdata = 32'h5A5A_1234;
      mem_ready = 1'b1;
      req_valid = '1;
      for (int g = 0; g < 6; g++) begin
         exp_q.push_back({1'b0, order[g], 32'h5A5A_1234});
      end
      for (int g = 0; g < 6; g++) begin
         step();
         total++;
         if (busy !== 1'b1 || grant_id !== order[g] ||
             mem_addr !== 32'h1000_0000 * (32'(order[g]) + 1)) begin
            bad++;
            $display("FAIL rr_grant g=%0d got busy=%b id=%0d addr=%h want busy=1 id=%0d", g, busy,
                     grant_id, mem_addr, order[g]);
         end
         step();
         total++;
         if (busy !== 1'b0 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle_gap g=%0d got busy=%b valid=%b want 0 0", g, busy, mem_valid);
         end
      end
      req_valid = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_timeout();
      mem_rdata = 32'hDEAD_BEEF;
      set_payload(1, 32'h0000_1110, 32'h0, 4'b0000);
      req_valid_t[1] = 1'b1;
      mem_ready_t    = 1'b0;
      exp_t_q.push_back({1'b1, 3'd1, 32'h0});
      step();
      for (int c = 1; c < 4; c++) begin
         total++;
         if (req_ready_t !== '0 || busy_t !== 1'b1 || mem_valid_t !== 1'b1) begin
            bad++;
            $display("FAIL to_early cyc=%0d got ready=%b busy=%b valid=%b want 000 1 1", c, req_ready_t,
                     busy_t, mem_valid_t);
         end
         step();
      end
      total++;
      if (req_ready_t !== 3'b010 || req_err_t !== 1'b1 || req_rdata_t !== 32'h0) begin
         bad++;
         $display("FAIL to_pulse got ready=%b err=%b rdata=%h want 010 1 00000000", req_ready_t,
                  req_err_t, req_rdata_t);
      end
      step();
      req_valid_t[1] = 1'b0;
      total++;
      if (mem_valid_t !== 1'b0 || busy_t !== 1'b0) begin
         bad++;
         $display("FAIL to_release got valid=%b busy=%b want 0 0", mem_valid_t, busy_t);
      end
      mem_ready_t = 1'b1;
      #1;
      total++;
      if (req_ready_t !== '0 || req_err_t !== 1'b0) begin
         bad++;
         $display("FAIL to_late_ready got ready=%b err=%b want 000 0", req_ready_t, req_err_t);
      end
      step();
      total++;
      if (busy_t !== 1'b0 || req_ready_t !== '0) begin
         bad++;
         $display("FAIL to_late_idle got busy=%b ready=%b want 0 000", busy_t, req_ready_t);
      end
      mem_ready_t = 1'b0;
   endtask

   task automatic test_ready_vs_timeout();
      set_payload(0, 32'h0000_0040, 32'h0, 4'b0000);
      req_valid_t[0] = 1'b1;
      mem_ready_t    = 1'b0;
      exp_t_q.push_back({1'b0, 3'd0, 32'h1357_9BDF});
      step();
      repeat (3) step();
      mem_ready_t = 1'b1;
      mem_rdata   = 32'h1357_9BDF;
      #1;
      total++;
      if (req_ready_t !== 3'b001 || req_err_t !== 1'b0 || req_rdata_t !== 32'h1357_9BDF) begin
         bad++;
         $display("FAIL tie_pulse got ready=%b err=%b rdata=%h want 001 0 13579bdf", req_ready_t,
                  req_err_t, req_rdata_t);
      end
      step();
      mem_ready_t    = 1'b0;
      req_valid_t[0] = 1'b0;
      total++;
      if (mem_valid_t !== 1'b0 || busy_t !== 1'b0) begin
         bad++;
         $display("FAIL tie_release got valid=%b busy=%b want 0 0", mem_valid_t, busy_t);
      end
   endtask

   task automatic test_reset_busy();
      set_payload(1, 32'h0000_3000, 32'h0, 4'b0000);
      req_valid[1] = 1'b1;
      mem_ready    = 1'b0;
      step();
      repeat (2) step();
      total++;
      if (busy !== 1'b1 || mem_valid !== 1'b1) begin
         bad++;
         $display("FAIL rb_pre got busy=%b valid=%b want 1 1", busy, mem_valid);
      end
      #2;
      resetn = 1'b0;
      #1;
      total++;
      if (mem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
         bad++;
         $display("FAIL rb_async got valid=%b busy=%b ready=%b want 0 0 000", mem_valid, busy, req_ready);
      end
      req_valid[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      set_payload(0, 32'h0000_0A00, 32'h0, 4'b0000);
      set_payload(2, 32'h0000_0C00, 32'h0, 4'b0000);
      req_valid = '1;
      exp_q.push_back({1'b0, 3'd0, 32'h7777_0000});
      step();
      total++;
      if (grant_id !== 3'd0 || mem_addr !== 32'h0000_0A00) begin
         bad++;
         $display("FAIL rb_first got id=%0d addr=%h want id=0 addr=00000a00", grant_id, mem_addr);
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h7777_0000;
      step();
      req_valid = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_drain();
      repeat (2) step();
      total++;
      if (exp_q.size() != 0 || exp_t_q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d/%0d want 0/0", exp_q.size(), exp_t_q.size());
      end
   endtask

   // Sequence
   initial begin
      test_reset();
      test_single_read();
      test_write_hold();
      test_round_robin();
      test_timeout();
      test_ready_vs_timeout();
      test_reset_busy();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
